floo_multicast_fork: RTL and testbench
======================================

// Module: floo_multicast_fork
// PURPOSE
// Request-side counterpart of the collective-response reduction arbiter. One input flit is replicated to a
// set of output routes given by a destination mask. Each output has its own independent handshake.
// The input is acknowledged only after every selected output has accepted its copy. The block sits in the
// router output stage, ahead of the per-route links. Responses coming back from those routes are merged later.
// PARAMETERS
// NumRoutes  5      number of output routes (>=1)
// flit_t     logic  flit type; copied unmodified to every selected output
// CntWidth   16     width of the fork-completion counter
// PORTS
// clk_i           in   1                 clock
// rst_i           in   1                 synchronous reset, active-high
// valid_i         in   1                 input flit valid
// ready_o         out  1                 input flit consumed (all copies delivered)
// data_i          in   $bits(flit_t)     input flit
// route_mask_i    in   NumRoutes         destination routes for data_i; sampled with the first valid cycle
// valid_o         out  NumRoutes         per-route output valid
// ready_i         in   NumRoutes         per-route output ready
// data_o          out  NumRoutes*flit_t  per-route flit (all equal to data_i)
// busy_o          out  1                 a flit is partially forwarded (state PARTIAL)
// empty_mask_o    out  1                 pulse: a flit with all-zero mask was dropped
// fork_cnt_o      out  CntWidth          number of completed multi-destination forks
// BEHAVIOUR
// - State register: state_q in {IDLE, PARTIAL}; sent_q[NumRoutes]; mask_q[NumRoutes]; cnt_q.
// - Reset (rst_i=1 at clk_i edge): state_q=IDLE, sent_q=0, mask_q=0, cnt_q=0, empty_mask_o=0.
//   Combinational outputs follow from these values: valid_o=0 unless valid_i is high; busy_o=0.
// - Effective mask: eff_mask = (state_q==IDLE) ? route_mask_i : mask_q.
//   route_mask_i is ignored while in PARTIAL.
// - valid_o[i] = valid_i & eff_mask[i] & ~sent_q[i]; data_o[i] = data_i. Combinational, zero latency.
// - acc[i] = valid_o[i] & ready_i[i]; done = ((sent_q | acc) & eff_mask) == eff_mask.
// - ready_o = valid_i & done. With an all-zero eff_mask, ready_o = valid_i (flit dropped).
// - empty_mask_o is registered: it is 1 in the cycle after an IDLE handshake with route_mask_i==0.
// - Transitions:
//   IDLE: valid_i & done -> stay IDLE, sent_q=0. Zero-cycle fork if all targets ready.
//   IDLE: valid_i & ~done -> PARTIAL, mask_q<=route_mask_i, sent_q<=acc.
//   PARTIAL: done -> IDLE, sent_q<=0. Otherwise sent_q<=sent_q|acc.
// - A route never sees a second copy of the same flit. Once acc[i] has fired, valid_o[i] stays low until the
//   input handshake completes.
// - Outputs may accept in any order and in different cycles. A route that is not ready never blocks the
//   others from accepting.
// - Input stream rules: valid_i and data_i stay stable until ready_o. Dropping valid_i while in PARTIAL is a
//   protocol violation (SVA assertion). The design does not recover from it.
// - cnt_q increments on ready_o when popcount(eff_mask) >= 2. It wraps modulo 2^CntWidth.
// - Back-to-back flits: a new flit is presented in the cycle after ready_o and starts from IDLE with sent_q=0.
// - rst_i asserted in PARTIAL aborts the fork. State returns to IDLE and sent_q is cleared.
//   Routes that already accepted keep their copy. Upstream must also be reset.
// - Single route (popcount==1) behaves as a plain pass-through. ready_o = ready_i[dst] when valid_i.
// TESTING
// 1. NumRoutes=5, mask=5'b10110, ready_i=5'b11111 -> valid_o=10110 and ready_o=1 in the same cycle;
//    fork_cnt_o=1.
// 2. mask=5'b00111, ready_i cycle0=001, cycle1=010, cycle2=100 -> each route gets exactly one valid;
//    ready_o only in cycle2; busy_o=1 in cycles 1-2.
// 3. mask=0, valid_i=1 -> ready_o=1 immediately, valid_o=0, empty_mask_o=1 next cycle, fork_cnt_o unchanged.
// 4. PARTIAL with sent_q=00001: route_mask_i changed to 11000 -> ignored; completion still needs routes 1,2.
// 5. rst_i pulsed during PARTIAL -> next cycle busy_o=0, sent_q=0; re-presented flit is sent to all mask routes.
// 6. 2^CntWidth+3 full forks (CntWidth=4) -> fork_cnt_o wraps to 3; random ready_i plus a scoreboard shows no
//    duplicate or lost copies.

Source files
------------

// File: rtl/floo_multicast_fork.sv
// Replicates one input flit to every route in a destination mask, each with its own handshake.
// The input is consumed once all selected routes have taken their copy.
module floo_multicast_fork #(
    parameter int unsigned NumRoutes = 5,
    parameter type         flit_t    = logic,
    parameter int unsigned CntWidth  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  flit_t                 data_i,
    input  logic [NumRoutes-1:0]  route_mask_i,
    output logic [NumRoutes-1:0]  valid_o,
    input  logic [NumRoutes-1:0]  ready_i,
    output flit_t [NumRoutes-1:0] data_o,
    output logic                  busy_o,
    output logic                  empty_mask_o,
    output logic [CntWidth-1:0]   fork_cnt_o
);

    typedef enum logic {StIdle, StPartial} state_e;

    state_e               state_q, state_d;
    logic [NumRoutes-1:0] sent_q, sent_d;
    logic [NumRoutes-1:0] mask_q, mask_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 empty_q, empty_d;

    logic [NumRoutes-1:0] eff_mask;
    logic [NumRoutes-1:0] acc;
    logic                 done;
    logic                 multi;

    // The mask is latched on the first cycle so a changing route_mask_i cannot alter a fork in flight.
    assign eff_mask = (state_q == StIdle) ? route_mask_i : mask_q;
    assign valid_o  = {NumRoutes{valid_i}} & eff_mask & ~sent_q;
    assign acc      = valid_o & ready_i;
    assign done     = ((sent_q | acc) & eff_mask) == eff_mask;
    assign ready_o  = valid_i & done;

    // Clearing the lowest set bit leaves something only if two or more routes are selected.
    assign multi = |(eff_mask & (eff_mask - NumRoutes'(1)));

    always_comb begin
        for (int unsigned i = 0; i < NumRoutes; i++) begin
            data_o[i] = data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        sent_d  = sent_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        empty_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (valid_i) begin
                    if (done) begin
                        sent_d  = '0;
                        empty_d = ~|route_mask_i;
                    end else begin
                        state_d = StPartial;
                        mask_d  = route_mask_i;
                        sent_d  = acc;
                    end
                end
            end
            StPartial: begin
                if (ready_o) begin
                    state_d = StIdle;
                    sent_d  = '0;
                end else begin
                    sent_d = sent_q | acc;
                end
            end
            default: state_d = StIdle;
        endcase
        if (ready_o && multi) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            sent_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sent_q  <= sent_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            empty_q <= empty_d;
        end
    end

    assign busy_o       = (state_q == StPartial);
    assign empty_mask_o = empty_q;
    assign fork_cnt_o   = cnt_q;

    // Withdrawing a partially forwarded flit would leave some routes with a copy and others without.
    valid_held_in_partial: assert property (
        @(posedge clk_i) disable iff (rst_i) (state_q == StPartial) |-> valid_i
    );

endmodule

// File: tb/tb_floo_multicast_fork.sv
// Directed and randomised-ready checks of floo_multicast_fork with five 8-bit routes and a 4-bit
// fork counter.
module tb_floo_multicast_fork;

    logic            clk = 1'b0;
    logic            rst_i;
    logic            valid_i;
    logic            ready_o;
    logic [7:0]      data_i;
    logic [4:0]      route_mask_i;
    logic [4:0]      valid_o;
    logic [4:0]      ready_i;
    logic [4:0][7:0] data_o;
    logic            busy_o;
    logic            empty_mask_o;
    logic [3:0]      fork_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    floo_multicast_fork #(
        .NumRoutes (5),
        .flit_t    (logic [7:0]),
        .CntWidth  (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .route_mask_i (route_mask_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .busy_o       (busy_o),
        .empty_mask_o (empty_mask_o),
        .fork_cnt_o   (fork_cnt_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [4:0] sb_mask;
    logic [7:0] sb_data;
    logic [4:0] delivered;
    logic       dup;
    logic       stray;
    logic       fdone;

    initial begin
        rst_i        = 1'b1;
        valid_i      = 1'b0;
        data_i       = '0;
        route_mask_i = '0;
        ready_i      = '0;
        step();
        step();
        rst_i = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_empty", 32'(empty_mask_o), 32'd0);
        check_eq("rst_cnt", 32'(fork_cnt_o), 32'd0);
        check_eq("rst_valid_o", 32'(valid_o), 32'd0);
        check_eq("rst_ready_o", 32'(ready_o), 32'd0);

        // Zero-cycle fork to three routes.
        valid_i = 1'b1; data_i = 8'hA5; route_mask_i = 5'b10110; ready_i = 5'b11111;
        #1;
        check_eq("t1_valid_o", 32'(valid_o), 32'b10110);
        check_eq("t1_ready_o", 32'(ready_o), 32'd1);
        check_eq("t1_data_o", 32'(data_o[1]), 32'hA5);
        step();
        check_eq("t1_cnt", 32'(fork_cnt_o), 32'd1);
        check_eq("t1_busy", 32'(busy_o), 32'd0);

        // Routes accept one per cycle.
        data_i = 8'h3C; route_mask_i = 5'b00111; ready_i = 5'b00001;
        #1;
        check_eq("t2_c0_valid_o", 32'(valid_o), 32'b00111);
        check_eq("t2_c0_ready_o", 32'(ready_o), 32'd0);
        step();
        ready_i = 5'b00010;
        #1;
        check_eq("t2_c1_busy", 32'(busy_o), 32'd1);
        check_eq("t2_c1_valid_o", 32'(valid_o), 32'b00110);
        check_eq("t2_c1_ready_o", 32'(ready_o), 32'd0);
        step();
        ready_i = 5'b00100;
        #1;
        check_eq("t2_c2_busy", 32'(busy_o), 32'd1);
        check_eq("t2_c2_valid_o", 32'(valid_o), 32'b00100);
        check_eq("t2_c2_ready_o", 32'(ready_o), 32'd1);
        step();
        check_eq("t2_cnt", 32'(fork_cnt_o), 32'd2);
        check_eq("t2_busy", 32'(busy_o), 32'd0);

        // Empty mask drops the flit.
        data_i = 8'h11; route_mask_i = 5'b00000; ready_i = 5'b00000;
        #1;
        check_eq("t3_ready_o", 32'(ready_o), 32'd1);
        check_eq("t3_valid_o", 32'(valid_o), 32'd0);
        step();
        valid_i = 1'b0;
        #1;
        check_eq("t3_empty", 32'(empty_mask_o), 32'd1);
        check_eq("t3_cnt", 32'(fork_cnt_o), 32'd2);
        step();
        check_eq("t3_empty_clr", 32'(empty_mask_o), 32'd0);

        // Mask change during PARTIAL is ignored.
        valid_i = 1'b1; data_i = 8'h77; route_mask_i = 5'b00111; ready_i = 5'b00001;
        step();
        route_mask_i = 5'b11000; ready_i = 5'b00000;
        #1;
        check_eq("t4_valid_o", 32'(valid_o), 32'b00110);
        check_eq("t4_ready_o_wait", 32'(ready_o), 32'd0);
        step();
        ready_i = 5'b11110;
        #1;
        check_eq("t4_valid_o2", 32'(valid_o), 32'b00110);
        check_eq("t4_ready_o", 32'(ready_o), 32'd1);
        step();
        check_eq("t4_cnt", 32'(fork_cnt_o), 32'd3);

        // Reset aborts a partial fork; the re-presented flit goes to every mask route.
        data_i = 8'h99; route_mask_i = 5'b01011; ready_i = 5'b00001;
        step();
        rst_i = 1'b1; ready_i = 5'b00000;
        #1;
        check_eq("t5_busy_pre", 32'(busy_o), 32'd1);
        check_eq("t5_valid_pre", 32'(valid_o), 32'b01010);
        step();
        rst_i = 1'b0; ready_i = 5'b01011;
        #1;
        check_eq("t5_busy", 32'(busy_o), 32'd0);
        check_eq("t5_valid_o", 32'(valid_o), 32'b01011);
        check_eq("t5_ready_o", 32'(ready_o), 32'd1);
        step();
        check_eq("t5_cnt", 32'(fork_cnt_o), 32'd1);

        // 19 back-to-back random forks from a cleared counter: wraps to 3.
        rst_i = 1'b1; valid_i = 1'b0;
        step();
        rst_i = 1'b0;
        #1;
        check_eq("t6_cnt0", 32'(fork_cnt_o), 32'd0);
        for (int f = 0; f < 19; f++) begin
            sb_mask = 5'($urandom);
            if (!(|(sb_mask & (sb_mask - 5'd1)))) sb_mask = sb_mask | 5'b10001;
            sb_data   = 8'($urandom);
            delivered = '0;
            dup       = 1'b0;
            stray     = 1'b0;
            fdone     = 1'b0;
            valid_i      = 1'b1;
            data_i       = sb_data;
            route_mask_i = sb_mask;
            for (int c = 0; c < 60 && !fdone; c++) begin
                ready_i = 5'($urandom);
                #1;
                if ((valid_o & ~sb_mask) != 5'd0) stray = 1'b1;
                for (int r = 0; r < 5; r++) begin
                    if (valid_o[r] && ready_i[r]) begin
                        if (delivered[r] || data_o[r] !== sb_data) dup = 1'b1;
                        delivered[r] = 1'b1;
                    end
                end
                fdone = ready_o;
                step();
                route_mask_i = 5'($urandom);
            end
            check_eq("t6_done", 32'(fdone), 32'd1);
            check_eq("t6_copies", 32'(delivered), 32'(sb_mask));
            check_eq("t6_dup", 32'(dup), 32'd0);
            check_eq("t6_stray", 32'(stray), 32'd0);
        end
        valid_i = 1'b0;
        #1;
        check_eq("t6_cnt_wrap", 32'(fork_cnt_o), 32'd3);
        check_eq("t6_busy", 32'(busy_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
